// File: rtl/barrel_arb_if.sv
// ============================================================================
// Module  : barrel_arb_if
// Purpose : Bundles both requester ports, the shared-shifter hookup and the
//           result port of barrel_arb into one interface.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface barrel_arb_if #(
   parameter int WIDTH = 16
);
   localparam int CTW = $clog2(WIDTH);

   logic             r0_valid;
   logic             r0_ready;
   logic [WIDTH-1:0] r0_in;
   logic [CTW-1:0]   r0_ct;
   logic             r0_dir;
   logic [1:0]       r0_type;

   logic             r1_valid;
   logic             r1_ready;
   logic [WIDTH-1:0] r1_in;
   logic [CTW-1:0]   r1_ct;
   logic             r1_dir;
   logic [1:0]       r1_type;

   logic [WIDTH-1:0] sh_in;
   logic [CTW-1:0]   sh_ct;
   logic             sh_dir;
   logic [1:0]       sh_type;
   logic [WIDTH-1:0] sh_out;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_id;

   // Environment side: requesters, the shifter itself and the result consumer
   modport master (
      output r0_valid, r0_in, r0_ct, r0_dir, r0_type,
      input  r0_ready,
      output r1_valid, r1_in, r1_ct, r1_dir, r1_type,
      input  r1_ready,
      input  sh_in, sh_ct, sh_dir, sh_type,
      output sh_out,
      input  res_valid, res_data, res_id,
      output res_ready
   );

   modport slave (
      input  r0_valid, r0_in, r0_ct, r0_dir, r0_type,
      output r0_ready,
      input  r1_valid, r1_in, r1_ct, r1_dir, r1_type,
      output r1_ready,
      output sh_in, sh_ct, sh_dir, sh_type,
      input  sh_out,
      output res_valid, res_data, res_id,
      input  res_ready
   );

endinterface

`default_nettype wire

// File: rtl/barrel_arb.sv
// ============================================================================
// Module  : barrel_arb
// Purpose : Two-requester arbiter driving one shared combinational barrel
//           shifter; result captured in a registered, id-tagged output.
//           Define BARREL_ARB_PRIO_EN for fixed priority (requester 0 wins),
//           otherwise round-robin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_arb #(
   parameter int WIDTH = 16
) (
   input  wire logic     clk,
   input  wire logic     rst,
   barrel_arb_if.slave   bus
);

   localparam int CTW = $clog2(WIDTH);

   logic             r_res_valid;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_id;

   logic             w_can_acc;
   logic             w_any;
   logic             w_acc;
   logic             w_gid;

`ifndef BARREL_ARB_PRIO_EN
   logic             r_rr;
`endif

   // Grant decision; reset gates acceptance so both readys stay low while rst is high
   always_comb begin
      w_can_acc = !r_res_valid || bus.res_ready;
      w_any     = bus.r0_valid || bus.r1_valid;
      w_acc     = w_can_acc && w_any && !rst;
`ifdef BARREL_ARB_PRIO_EN
      w_gid     = !bus.r0_valid;
`else
      w_gid     = (bus.r0_valid && bus.r1_valid) ? r_rr : bus.r1_valid;
`endif
   end

   always_comb begin
      bus.r0_ready = w_acc && !w_gid;
      bus.r1_ready = w_acc && w_gid;
   end

   always_comb begin
      bus.sh_in   = '0;
      bus.sh_ct   = '0;
      bus.sh_dir  = 1'b0;
      bus.sh_type = 2'd0;
      if (w_acc) begin
         if (w_gid) begin
            bus.sh_in   = bus.r1_in;
            bus.sh_ct   = bus.r1_ct;
            bus.sh_dir  = bus.r1_dir;
            bus.sh_type = bus.r1_type;
         end else begin
            bus.sh_in   = bus.r0_in;
            bus.sh_ct   = bus.r0_ct;
            bus.sh_dir  = bus.r0_dir;
            bus.sh_type = bus.r0_type;
         end
      end
   end

   // A new accept overwrites a result being drained in the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_id    <= 1'b0;
      end else if (w_acc) begin
         r_res_valid <= 1'b1;
         r_res_data  <= bus.sh_out;
         r_res_id    <= w_gid;
      end else if (bus.res_ready) begin
         r_res_valid <= 1'b0;
      end
   end

`ifndef BARREL_ARB_PRIO_EN
   // Fairness pointer moves only on accept; idle cycles leave it alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr <= 1'b0;
      end else if (w_acc) begin
         r_rr <= !w_gid;
      end
   end
`endif

   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign bus.res_id    = r_res_id;

endmodule

`default_nettype wire

// File: tb/tb_barrel_arb.sv
// ============================================================================
// Module  : tb_barrel_arb
// Purpose : Directed plus short random stimulus for barrel_arb with a
//           reference shifter and an expected-result queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_arb;

   localparam int WIDTH = 16;
   localparam int CTW   = 4;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             id;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   barrel_arb_if #(.WIDTH(WIDTH)) bus ();

   barrel_arb #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   res_t q[$];
   int   total = 0;
   int   bad   = 0;
   logic m_valid;
   logic m_rr;

   // Reference barrel shifter: 0=NS 1=LO 2=AR 3=RO, dir 1 = left
   function automatic logic [WIDTH-1:0] shf(input logic [WIDTH-1:0] d, input logic [CTW-1:0] c,
                                            input logic dir, input logic [1:0] t);
      logic signed [WIDTH-1:0] s;
      s = d;
      case (t)
         2'd1: begin
            if (dir) return d << c;
            else     return d >> c;
         end
         2'd2: begin
            if (dir) return d << c;
            else     return s >>> c;
         end
         2'd3: begin
            if (dir) return (d << c) | (d >> (WIDTH - int'(c)));
            else     return (d >> c) | (d << (WIDTH - int'(c)));
         end
         default: return d;
      endcase
   endfunction

   always_comb bus.sh_out = shf(bus.sh_in, bus.sh_ct, bus.sh_dir, bus.sh_type);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_r(input int n, input logic v, input logic [WIDTH-1:0] d,
                        input logic [CTW-1:0] c, input logic dr, input logic [1:0] t);
      if (n == 0) begin
         bus.r0_valid = v; bus.r0_in = d; bus.r0_ct = c; bus.r0_dir = dr; bus.r0_type = t;
      end else begin
         bus.r1_valid = v; bus.r1_in = d; bus.r1_ct = c; bus.r1_dir = dr; bus.r1_type = t;
      end
   endtask

   // One clock: predict grant from the model, check combinational side, then the result
   task automatic cyc(output logic a0, output logic a1);
      logic             can, gany, gid, drain;
      logic [31:0]      esh;
      res_t             nr;
      can  = !m_valid || bus.res_ready;
      gany = can && (bus.r0_valid || bus.r1_valid);
`ifdef BARREL_ARB_PRIO_EN
      gid  = !bus.r0_valid;
`else
      gid  = (bus.r0_valid && bus.r1_valid) ? m_rr : bus.r1_valid;
`endif
      a0 = gany && !gid;
      a1 = gany && gid;
      esh = '0;
      nr  = '0;
      if (a0) begin
         esh = {9'd0, bus.r0_in, bus.r0_ct, bus.r0_dir, bus.r0_type};
         nr  = '{data: shf(bus.r0_in, bus.r0_ct, bus.r0_dir, bus.r0_type), id: 1'b0};
      end else if (a1) begin
         esh = {9'd0, bus.r1_in, bus.r1_ct, bus.r1_dir, bus.r1_type};
         nr  = '{data: shf(bus.r1_in, bus.r1_ct, bus.r1_dir, bus.r1_type), id: 1'b1};
      end
      #1;
      chk("r0_ready", bus.r0_ready, a0);
      chk("r1_ready", bus.r1_ready, a1);
      chk("sh_bus", {9'd0, bus.sh_in, bus.sh_ct, bus.sh_dir, bus.sh_type}, esh);
      drain = m_valid && bus.res_ready;
      @(posedge clk);
      #1;
      if (drain) void'(q.pop_front());
      if (gany) begin
         q.push_back(nr);
         m_valid = 1'b1;
         m_rr    = !gid;
      end else if (drain) begin
         m_valid = 1'b0;
      end
      chk("res_valid", bus.res_valid, m_valid);
      if (m_valid && q.size() > 0) begin
         chk("res_data", bus.res_data, q[0].data);
         chk("res_id", bus.res_id, q[0].id);
      end
   endtask

   initial begin
      logic       a0, a1, h0, h1;
      logic [3:0] seq;

      rst = 1'b1;
      bus.res_ready = 1'b0;
      set_r(0, 1'b0, '0, '0, 1'b0, 2'd0);
      set_r(1, 1'b0, '0, '0, 1'b0, 2'd0);
      m_valid = 1'b0;
      m_rr    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_res_data", bus.res_data, 16'h0000);
      chk("rst_res_id", bus.res_id, 1'b0);
      rst = 1'b0;

      // Single rotate-left op from r0
      bus.res_ready = 1'b1;
      set_r(0, 1'b1, 16'h8001, 4'd1, 1'b1, 2'd3);
      cyc(a0, a1);
      chk("t2_data", bus.res_data, 16'h0003);
      chk("t2_id", bus.res_id, 1'b0);
      set_r(0, 1'b0, '0, '0, 1'b0, 2'd0);
      cyc(a0, a1);

      // Back-to-back r1: AR right then LO left
      set_r(1, 1'b1, 16'hF000, 4'd4, 1'b0, 2'd2);
      cyc(a0, a1);
      chk("t5_data0", bus.res_data, 16'hFF00);
      set_r(1, 1'b1, 16'h00FF, 4'd8, 1'b1, 2'd1);
      cyc(a0, a1);
      chk("t5_data1", bus.res_data, 16'hFF00);
      chk("t5_id", bus.res_id, 1'b1);
      set_r(1, 1'b0, '0, '0, 1'b0, 2'd0);

      // Contention with no backpressure
`ifdef BARREL_ARB_PRIO_EN
      seq = 4'b0000;
`else
      seq = 4'b1010;
`endif
      set_r(0, 1'b1, 16'h1234, 4'd4, 1'b0, 2'd1);
      set_r(1, 1'b1, 16'h8421, 4'd3, 1'b0, 2'd3);
      for (int i = 0; i < 4; i++) begin
         cyc(a0, a1);
         chk("t3_id", bus.res_id, seq[i]);
      end
      set_r(0, 1'b0, '0, '0, 1'b0, 2'd0);
      set_r(1, 1'b0, '0, '0, 1'b0, 2'd0);
      cyc(a0, a1);

      // Backpressure: result held, r1 blocked, then accepted on drain
      set_r(0, 1'b1, 16'hA5A5, 4'd0, 1'b1, 2'd3);
      cyc(a0, a1);
      set_r(0, 1'b0, '0, '0, 1'b0, 2'd0);
      set_r(1, 1'b1, 16'h8000, 4'd15, 1'b0, 2'd2);
      bus.res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(a0, a1);
         chk("t4_stall_data", bus.res_data, 16'hA5A5);
      end
      bus.res_ready = 1'b1;
      cyc(a0, a1);
      chk("t4_new_data", bus.res_data, 16'hFFFF);
      chk("t4_new_id", bus.res_id, 1'b1);
      set_r(1, 1'b0, '0, '0, 1'b0, 2'd0);
      cyc(a0, a1);

      // Idle gap keeps fairness pointer
      set_r(1, 1'b1, 16'h0F0F, 4'd2, 1'b1, 2'd0);
      cyc(a0, a1);
      set_r(1, 1'b0, '0, '0, 1'b0, 2'd0);
      cyc(a0, a1);
      cyc(a0, a1);
      set_r(0, 1'b1, 16'h0001, 4'd5, 1'b1, 2'd1);
      set_r(1, 1'b1, 16'h0002, 4'd5, 1'b1, 2'd1);
      cyc(a0, a1);
      chk("t6_id", bus.res_id, 1'b0);
      chk("t6_data", bus.res_data, 16'h0020);
      set_r(0, 1'b0, '0, '0, 1'b0, 2'd0);
      set_r(1, 1'b0, '0, '0, 1'b0, 2'd0);
      cyc(a0, a1);

      // Random traffic, fields held stable while waiting
      h0 = 1'b0;
      h1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!h0) set_r(0, 1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
         if (!h1) set_r(1, 1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
         bus.res_ready = 1'($urandom);
         cyc(a0, a1);
         h0 = bus.r0_valid && !a0;
         h1 = bus.r1_valid && !a1;
      end

      // Asynchronous reset with a result pending
      bus.res_ready = 1'b1;
      set_r(0, 1'b1, 16'h00F0, 4'd4, 1'b1, 2'd1);
      set_r(1, 1'b0, '0, '0, 1'b0, 2'd0);
      cyc(a0, a1);
      set_r(1, 1'b1, 16'h0C00, 4'd2, 1'b0, 2'd1);
      bus.res_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("t1_res_valid", bus.res_valid, 1'b0);
      chk("t1_res_data", bus.res_data, 16'h0000);
      chk("t1_res_id", bus.res_id, 1'b0);
      chk("t1_ready", {bus.r0_ready, bus.r1_ready}, 2'b00);
      q.delete();
      m_valid = 1'b0;
      m_rr    = 1'b0;
      @(posedge clk);
      #1;
      chk("t1_ready_hold", {bus.r0_ready, bus.r1_ready}, 2'b00);
      rst = 1'b0;
      bus.res_ready = 1'b1;
      cyc(a0, a1);
      chk("t1_after_id", bus.res_id, 1'b0);
      chk("t1_after_data", bus.res_data, 16'h0F00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
